con_ff_unit: RTL and testbench

- Parametrised successor to the CPU's branch-condition (CON FF) logic.
- On a CONin strobe it captures the bus value and a 3-bit condition field, evaluates the condition one cycle later and registers the result into the CON flip-flop.
- Provides a valid pulse, a busy indication, overrun detection and saturating taken/evaluated statistics counters for the control unit and debug.
- Sits beside the datapath bus; its con_out feeds the control unit's conditional-branch sequencing.

---
 rtl/con_ff_unit.sv | 130 +++++++++++++
 tb/tb_con_ff_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/con_ff_unit.sv
// ---------------------------------------------------------------------------
// con_ff_unit
//   Branch-condition (CON FF) unit. A con_in strobe captures the bus value and
//   a 3-bit condition select. One cycle later the condition is evaluated and
//   the result is registered into the CON flip-flop. The unit also reports a
//   one-cycle valid pulse, busy, a sticky overrun flag and two saturating
//   statistics counters.
//
// Parameters
//   DATA_WIDTH : bus operand width (sign bit is DATA_WIDTH-1)
//   STAT_WIDTH : width of each statistics counter
//
// Ports
//   clock       in   system clock, rising edge
//   clear       in   synchronous active-high reset
//   con_in      in   capture strobe
//   c2_field    in   [2:0] condition select
//   bus         in   [DATA_WIDTH-1:0] operand to test
//   stat_clr    in   synchronous clear of counters and overrun
//   con_out     out  registered CON flag
//   con_valid   out  one-cycle pulse after con_out update
//   busy        out  evaluation in flight
//   overrun     out  sticky, strobe arrived while busy
//   taken_count out  [STAT_WIDTH-1:0] evaluations with result 1
//   eval_count  out  [STAT_WIDTH-1:0] evaluations completed
// ---------------------------------------------------------------------------
module con_ff_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  con_in,
    input  logic [2:0]            c2_field,
    input  logic [DATA_WIDTH-1:0] bus,
    input  logic                  stat_clr,
    output logic                  con_out,
    output logic                  con_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic [STAT_WIDTH-1:0] taken_count,
    output logic [STAT_WIDTH-1:0] eval_count
);

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    state_t                        state;
    logic signed [DATA_WIDTH-1:0]  op_p0;
    logic [2:0]                    cond_p0;
    logic                          result_p1;

    // Condition table: Z = operand is zero, S = operand sign bit.
    function automatic logic eval_cond(input logic [2:0] c,
                                       input logic signed [DATA_WIDTH-1:0] v);
        logic z;
        logic s;
        z = (v == '0);
        s = v[DATA_WIDTH-1];
        case (c)
            3'b000:  eval_cond = z;
            3'b001:  eval_cond = !z;
            3'b010:  eval_cond = !s;
            3'b011:  eval_cond = s;
            3'b100:  eval_cond = 1'b1;
            3'b101:  eval_cond = 1'b0;
            3'b110:  eval_cond = !s && !z;
            default: eval_cond = s || z;
        endcase
    endfunction

    // Counters stick at all ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] x);
        if (&x)
            sat_inc = x;
        else
            sat_inc = x + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign result_p1 = eval_cond(cond_p0, op_p0);

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            op_p0       <= '0;
            cond_p0     <= '0;
            con_out     <= 1'b0;
            con_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            taken_count <= '0;
            eval_count  <= '0;
        end else begin
            con_valid <= 1'b0;
            case (state)
                // Stage p0: capture operand and condition on the strobe.
                IDLE: begin
                    if (con_in) begin
                        op_p0   <= bus;
                        cond_p0 <= c2_field;
                        busy    <= 1'b1;
                        state   <= EVAL;
                    end
                end
                // Stage p1: evaluate, update CON flag and statistics.
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    con_out   <= result_p1;
                    con_valid <= 1'b1;
                    eval_count <= sat_inc(eval_count);
                    if (result_p1)
                        taken_count <= sat_inc(taken_count);
                    // A strobe while busy is dropped; operands stay put.
                    if (con_in)
                        overrun <= 1'b1;
                end
            endcase
            // Statistics clear wins over any same-edge increment or overrun set.
            if (stat_clr) begin
                taken_count <= '0;
                eval_count  <= '0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_con_ff_unit.sv
module tb_con_ff_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        con_in = 1'b0;
    logic [2:0]  c2_field = '0;
    logic [31:0] bus = '0;
    logic        stat_clr = 1'b0;

    logic        con_out_a, con_valid_a, busy_a, overrun_a;
    logic [15:0] taken_a, eval_a;
    logic        con_out_b, con_valid_b, busy_b, overrun_b;
    logic [1:0]  taken_b, eval_b;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: a pending capture plus result/statistics bookkeeping.
    bit          m_pend;
    logic [31:0] m_op;
    int          m_cond;
    bit          m_con, m_valid, m_ovr;
    int          m_eval16, m_taken16, m_eval2, m_taken2;

    con_ff_unit #(.DATA_WIDTH(32), .STAT_WIDTH(16)) dut (
        .clock(clock), .clear(clear), .con_in(con_in), .c2_field(c2_field),
        .bus(bus), .stat_clr(stat_clr), .con_out(con_out_a),
        .con_valid(con_valid_a), .busy(busy_a), .overrun(overrun_a),
        .taken_count(taken_a), .eval_count(eval_a));

    con_ff_unit #(.DATA_WIDTH(32), .STAT_WIDTH(2)) dut_s (
        .clock(clock), .clear(clear), .con_in(con_in), .c2_field(c2_field),
        .bus(bus), .stat_clr(stat_clr), .con_out(con_out_b),
        .con_valid(con_valid_b), .busy(busy_b), .overrun(overrun_b),
        .taken_count(taken_b), .eval_count(eval_b));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Condition meaning expressed as signed comparisons against zero.
    function automatic bit f_ref(input int c, input logic [31:0] v);
        int signed s;
        s = $signed(v);
        case (c)
            0: return s == 0;
            1: return s != 0;
            2: return s >= 0;
            3: return s < 0;
            4: return 1'b1;
            5: return 1'b0;
            6: return s > 0;
            default: return s <= 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_edge();
        bit r;
        m_valid = 1'b0;
        if (clear) begin
            m_pend = 0; m_op = '0; m_cond = 0; m_con = 0; m_ovr = 0;
            m_eval16 = 0; m_taken16 = 0; m_eval2 = 0; m_taken2 = 0;
            return;
        end
        if (m_pend) begin
            r = f_ref(m_cond, m_op);
            m_con = r;
            m_valid = 1'b1;
            m_eval16  = sat(m_eval16 + 1, 65535);
            m_eval2   = sat(m_eval2 + 1, 3);
            m_taken16 = sat(m_taken16 + int'(r), 65535);
            m_taken2  = sat(m_taken2 + int'(r), 3);
            if (con_in) m_ovr = 1'b1;
            m_pend = 0;
        end else if (con_in) begin
            m_pend = 1;
            m_op = bus;
            m_cond = int'(c2_field);
        end
        if (stat_clr) begin
            m_eval16 = 0; m_taken16 = 0; m_eval2 = 0; m_taken2 = 0; m_ovr = 0;
        end
    endtask

    task automatic compare_all();
        chk("con_out",     32'(con_out_a),   32'(m_con));
        chk("con_valid",   32'(con_valid_a), 32'(m_valid));
        chk("busy",        32'(busy_a),      32'(m_pend));
        chk("overrun",     32'(overrun_a),   32'(m_ovr));
        chk("taken_count", 32'(taken_a),     32'(m_taken16));
        chk("eval_count",  32'(eval_a),      32'(m_eval16));
        chk("w2_con_out",  32'(con_out_b),   32'(m_con));
        chk("w2_taken",    32'(taken_b),     32'(m_taken2));
        chk("w2_eval",     32'(eval_b),      32'(m_eval2));
    endtask

    task automatic step(input bit clr, input bit ci, input logic [2:0] c,
                        input logic [31:0] b, input bit sc);
        clear = clr; con_in = ci; c2_field = c; bus = b; stat_clr = sc;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    logic [2:0]  tbl [8];
    logic [31:0] sweep_bus [3];

    initial begin
        tbl = '{3'b100, 3'b011, 3'b110, 3'b001, 3'b111, 3'b000, 3'b010, 3'b101};
        sweep_bus = '{32'h0, 32'h5, 32'h8000_0000};
        m_pend = 0; m_op = '0; m_cond = 0; m_con = 0; m_valid = 0; m_ovr = 0;
        m_eval16 = 0; m_taken16 = 0; m_eval2 = 0; m_taken2 = 0;

        // Reset with aggressive inputs.
        step(1, 1, 3'd4, 32'hFFFF_FFFF, 0);
        step(1, 1, 3'd4, 32'hFFFF_FFFF, 0);
        chk("rst_con_out", 32'(con_out_a), 32'd0);
        chk("rst_busy",    32'(busy_a),    32'd0);
        chk("rst_eval",    32'(eval_a),    32'd0);

        // Reset during evaluation discards it.
        step(0, 1, 3'd4, 32'h1, 0);
        chk("busy_after_strobe", 32'(busy_a), 32'd1);
        step(1, 0, 3'd0, 32'h0, 0);
        step(0, 0, 3'd0, 32'h0, 0);
        chk("rst_mid_valid", 32'(con_valid_a), 32'd0);
        chk("rst_mid_eval",  32'(eval_a),      32'd0);

        // Encoding sweep against the fixed truth table.
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 3; k++) begin
                logic [2:0] row;
                row = tbl[c];
                step(0, 1, 3'(c), sweep_bus[k], 0);
                chk("sweep_no_early_valid", 32'(con_valid_a), 32'd0);
                step(0, 0, 3'(c), 32'h0, 0);
                chk($sformatf("sweep_c%0d_b%0d", c, k), 32'(con_out_a), 32'(row[2-k]));
                chk("sweep_valid", 32'(con_valid_a), 32'd1);
                step(0, 0, 3'd0, 32'h0, 0);
                chk("sweep_valid_drop", 32'(con_valid_a), 32'd0);
            end
        end

        // Bus changes after capture are ignored.
        step(0, 1, 3'd0, 32'h0, 0);
        step(0, 0, 3'd0, 32'h7, 0);
        chk("capture_isolation", 32'(con_out_a), 32'd1);

        // Overrun: two-cycle strobe yields one evaluation.
        step(0, 0, 3'd0, 32'h0, 1);
        step(0, 1, 3'd5, 32'h0, 0);
        step(0, 1, 3'd4, 32'h0, 0);
        step(0, 0, 3'd0, 32'h0, 0);
        chk("ovr_eval",    32'(eval_a),    32'd1);
        chk("ovr_flag",    32'(overrun_a), 32'd1);
        chk("ovr_con_out", 32'(con_out_a), 32'd0);
        step(0, 0, 3'd0, 32'h0, 1);
        chk("ovr_clr_flag",    32'(overrun_a), 32'd0);
        chk("ovr_clr_eval",    32'(eval_a),    32'd0);
        chk("ovr_clr_con_out", 32'(con_out_a), 32'd0);

        // Saturation on the narrow instance.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 3'd4, 32'h0, 0);
            step(0, 0, 3'd0, 32'h0, 0);
        end
        chk("sat_taken", 32'(taken_b), 32'd3);
        chk("sat_eval",  32'(eval_b),  32'd3);
        chk("wide_eval", 32'(eval_a),  32'd5);

        // stat_clr on the completion edge.
        step(0, 1, 3'd5, 32'h0, 0);
        step(0, 0, 3'd0, 32'h0, 1);
        chk("simul_valid",   32'(con_valid_a), 32'd1);
        chk("simul_con_out", 32'(con_out_a),   32'd0);
        chk("simul_eval",    32'(eval_a),      32'd0);
        chk("simul_taken",   32'(taken_a),     32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit          r_clr, r_sc, r_ci;
            logic [31:0] r_bus;
            r_clr = ($urandom_range(0, 49) == 0);
            r_sc  = ($urandom_range(0, 29) == 0);
            r_ci  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       r_bus = 32'h0;
                1:       r_bus = 32'h8000_0000 | $urandom;
                default: r_bus = $urandom;
            endcase
            step(r_clr, r_ci, 3'($urandom_range(0, 7)), r_bus, r_sc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
